// File: rtl/encoder_scheduler_if.sv
// Control/status bundle between the encoder scheduler and its host.
// Signal widths derive from NUM_ENC exactly as in the scheduler itself.
interface encoder_scheduler_if #(
    parameter int unsigned NUM_ENC = 2
);
    localparam int unsigned PERIOD = 4 * NUM_ENC;
    localparam int unsigned PW     = $clog2(PERIOD);
    localparam int unsigned SW     = $clog2(NUM_ENC);

    logic               enable;
    logic               bx0_sync;
    logic [PW-1:0]      latch_offset;
    logic [3:0]         sel_delay;
    logic               clear_err;
    logic [NUM_ENC-1:0] latch;
    logic [SW-1:0]      mux_sel;
    logic               frame_start;
    logic [PW-1:0]      phase;
    logic [1:0]         state;
    logic               misalign;
    logic [7:0]         resync_cnt;

    modport master (
        output enable, bx0_sync, latch_offset, sel_delay, clear_err,
        input  latch, mux_sel, frame_start, phase, state, misalign, resync_cnt
    );

    modport slave (
        input  enable, bx0_sync, latch_offset, sel_delay, clear_err,
        output latch, mux_sel, frame_start, phase, state, misalign, resync_cnt
    );
endinterface

// File: rtl/encoder_scheduler.sv
// Round-robin latch sequencer for the priority-encoder bank: BX0-aligned
// phase counter, per-encoder latch strobes, delayed mux select, resync tracking.
module encoder_scheduler #(
    parameter int unsigned NUM_ENC = 2
) (
    input  logic               clock4x,
    input  logic               global_reset_n,
    encoder_scheduler_if.slave bus
);
    localparam int unsigned PERIOD = 4 * NUM_ENC;
    localparam int unsigned PW     = $clog2(PERIOD);
    localparam int unsigned SW     = $clog2(NUM_ENC);
    localparam int unsigned DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_phase;
    logic [PW-1:0]      r_offset;
    logic [3:0]         r_sel_delay;
    logic [NUM_ENC-1:0] r_latch;
    logic               r_frame_start;
    logic               r_misalign;
    logic [7:0]         r_resync_cnt;
    logic [SW-1:0]      r_line [DEPTH];
    logic [SW-1:0]      r_mux_sel;

    logic               w_run;
    logic               w_last;
    logic               w_resync;
    logic               w_shadow_ld;
    logic [SW-1:0]      w_sel_raw;
    logic [NUM_ENC-1:0] w_slot_hit;

    assign w_run       = (r_state == ST_RUN);
    assign w_last      = (r_phase == PW'(PERIOD - 1));
    // Enable drop outranks a coincident BX0, so no resync is counted then.
    assign w_resync    = w_run && bus.enable && bus.bx0_sync && !w_last;
    assign w_shadow_ld = !w_run || w_last || w_resync;
    assign w_sel_raw   = w_run ? SW'(r_phase >> 2) : '0;

    for (genvar i = 0; i < NUM_ENC; i++) begin : g_slot
        assign w_slot_hit[i] = (r_phase == PW'(r_offset + PW'(4 * i)));
    end

    // Sequencer FSM with phase counter and strobe outputs.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state       <= ST_IDLE;
            r_phase       <= '0;
            r_latch       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_latch       <= '0;
            r_frame_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_phase <= '0;
                    if (bus.enable) begin
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    r_phase <= '0;
                    if (!bus.enable) begin
                        r_state <= ST_IDLE;
                    end else if (bus.bx0_sync) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_latch       <= w_slot_hit;
                    r_frame_start <= (r_phase == '0);
                    if (!bus.enable) begin
                        r_state <= ST_IDLE;
                        r_phase <= '0;
                    end else if (w_resync) begin
                        r_phase <= '0;
                    end else begin
                        r_phase <= PW'(r_phase + 1'b1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_phase <= '0;
                end
            endcase
        end
    end

    // Configuration shadows only move on frame boundaries while running.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_offset    <= '0;
            r_sel_delay <= '0;
        end else if (w_shadow_ld) begin
            r_offset    <= bus.latch_offset;
            r_sel_delay <= bus.sel_delay;
        end
    end

    // Sticky misalignment flag and saturating resync counter; clear wins.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_misalign   <= 1'b0;
            r_resync_cnt <= '0;
        end else if (bus.clear_err) begin
            r_misalign   <= 1'b0;
            r_resync_cnt <= '0;
        end else if (w_resync) begin
            r_misalign <= 1'b1;
            if (r_resync_cnt != 8'hFF) begin
                r_resync_cnt <= r_resync_cnt + 8'd1;
            end
        end
    end

    // Free-running select delay line; the tap moves without flushing.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_line[k] <= '0;
            end
            r_mux_sel <= '0;
        end else begin
            r_line[0] <= w_sel_raw;
            for (int k = 1; k < DEPTH; k++) begin
                r_line[k] <= r_line[k-1];
            end
            r_mux_sel <= r_line[r_sel_delay];
        end
    end

    assign bus.latch       = r_latch;
    assign bus.mux_sel     = r_mux_sel;
    assign bus.frame_start = r_frame_start;
    assign bus.phase       = r_phase;
    assign bus.state       = 2'(r_state);
    assign bus.misalign    = r_misalign;
    assign bus.resync_cnt  = r_resync_cnt;

endmodule
